launchpad_key_scanner: RTL
==========================

// Module: launchpad_key_scanner
// PURPOSE
//   Scans the 4x4 launchpad key matrix, debounces each key and produces clean key levels and
//   one-cycle press pulses. Sits directly upstream of the 8-digit segment handler.
//   event_8 and event_12 drive that handler's event inputs, which are sampled on its slow clock.
//   key_level/key_pulse are exported for the sound and LED stages.
// PARAMETERS
//   SCAN_DIV        5000  CLK cycles each column is driven; legal range >= 4
//   DEBOUNCE_SCANS  4     consecutive identical full-matrix snapshots needed to accept a change; >= 2
// PORTS
//   CLK        in   1   system clock; all logic on the rising edge
//   RST        in   1   asynchronous, active-high reset
//   key_row    in   4   matrix rows, active-low, external pull-ups, asynchronous to CLK
//   key_col    out  4   matrix column drive, active-low one-hot
//   key_level  out  16  debounced key state, 1 = pressed; index = col*4 + row
//   key_pulse  out  16  1-CLK pulse on each 0->1 transition of key_level
//   scan_done  out  1   1-CLK pulse when a full 4-column snapshot completes
//   event_8    out  1   key_level[8]
//   event_12   out  1   key_level[12]
// BEHAVIOUR
//   Clock and reset: one clock (CLK); reset RST is asynchronous and active-high.
//   Reset values (async, immediate, also mid-scan): key_col=4'b1110, div=0, col=0, snapshot/prev=0,
//     stable_cnt=0, key_level=0, key_pulse=0, scan_done=0, event_8=0, event_12=0.
//   Row sync: key_row goes through a 2-FF synchroniser and is inverted (pressed = 1) before use.
//   Divider: div counts 0..SCAN_DIV-1 and wraps. On div==SCAN_DIV-1 (slot end):
//     - snapshot[col*4 +: 4] <= synced rows
//     - col advances 0->1->2->3->0; key_col <= ~(4'b0001 << next col)
//     Sampling at slot end leaves at least 3 settle cycles after the column switch.
//   At the slot end of col 3, the full snapshot is assembled; on the next cycle:
//     - scan_done=1
//     - compare assembled snapshot to prev:
//       - equal: stable_cnt increments, saturating at DEBOUNCE_SCANS-1
//       - different: stable_cnt=0
//     - prev <= snapshot
//     - if the (new) stable_cnt == DEBOUNCE_SCANS-1, key_level <= snapshot
//   key_pulse = key_level & ~key_level_d (registered previous value); exactly 1 CLK wide, 0 on release.
//   Multiple simultaneous keys are reported independently; no ghost rejection.
//   Latency: a press held steady is accepted at the end of its DEBOUNCE_SCANS-th complete
//     snapshot, i.e. between (DEBOUNCE_SCANS)*4*SCAN_DIV and (DEBOUNCE_SCANS+1)*4*SCAN_DIV+3 CLKs.
//     Release follows the same timing.
//   Bounce: any snapshot differing from prev restarts the count; key_level holds its old value.
//   A change landing mid-scan yields a mixed snapshot, which is treated as an ordinary difference.
// STRUCTURE
//   Shared package: NUM_KEYS=16, NUM_ROWS=4, NUM_COLS=4, KEY_EVENT_8=8, KEY_EVENT_12=12.
//   One sub-module, scan_tick_gen: divider plus column counter; outputs slot_end, col, key_col.
//   Synchroniser, snapshot/debounce and edge detect stay in this module.
// TESTING  (bench params SCAN_DIV=4, DEBOUNCE_SCANS=3 -> 16 CLK per scan)
//   1. RST=1 mid-scan with key 8 accepted -> same cycle: key_level=0, event_8=0, key_col=4'b1110;
//      after release, first column switch occurs on CLK 4.
//   2. Hold row0 low whenever key_col[2]=0 (key 8) -> key_level[8] rises within 48..67 CLK;
//      key_pulse[8]=1 for exactly 1 CLK; event_8=1; scan_done every 16 CLK.
//   3. Press key 8 on alternate scans (bounce) for 10 scans -> key_level[8] stays 0, no pulse.
//   4. Release accepted key 8 -> key_level[8] falls after 3 stable scans; key_pulse stays 0.
//   5. Press keys 8 and 12 (row0 on cols 2 and 3) together -> both levels rise on the same CLK,
//      event_8=event_12=1, key_pulse=16'h1100 for 1 CLK.
//   6. Press key 5 (col1, row1) while key 8 is held -> key_level=16'h0120; key 8 gives no repeat pulse.

Source files
------------

// File: rtl/launchpad_key_scanner_pkg.sv
// launchpad_key_scanner_pkg: matrix geometry, event key indices and column drive helper
package launchpad_key_scanner_pkg;
  localparam int NUM_KEYS = 16;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_EVENT_8 = 8;
  localparam int KEY_EVENT_12 = 12;
  typedef logic [NUM_KEYS-1:0] key_vec_t;
  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction
endpackage

// File: rtl/launchpad_key_scanner_scan_tick_gen.sv
// launchpad_key_scanner_scan_tick_gen: slot divider and active-low one-hot column sequencer
module launchpad_key_scanner_scan_tick_gen
  import launchpad_key_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 5000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                slot_end_o,
  output logic [1:0]          col_o,
  output logic [NUM_COLS-1:0] key_col_o
);
  localparam int DW = $clog2(SCAN_DIV);
  logic [DW-1:0] div_q, div_d;
  logic [1:0] col_q, col_d;
  logic [NUM_COLS-1:0] key_col_q, key_col_d;
  always_comb begin
    slot_end_o = div_q == DW'(SCAN_DIV - 1);
    div_d = slot_end_o ? '0 : div_q + 1'b1;
    col_d = slot_end_o ? col_q + 2'd1 : col_q;
    key_col_d = slot_end_o ? col_drive(col_q + 2'd1) : key_col_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
      col_q <= '0;
      key_col_q <= 4'b1110;
    end else begin
      div_q <= div_d;
      col_q <= col_d;
      key_col_q <= key_col_d;
    end
  end
  assign col_o = col_q;
  assign key_col_o = key_col_q;
endmodule

// File: rtl/launchpad_key_scanner.sv
// launchpad_key_scanner: scans the 4x4 key matrix, debounces whole-matrix snapshots,
// and emits clean key levels plus one-cycle press pulses.
module launchpad_key_scanner
  import launchpad_key_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_ROWS-1:0] key_row,
  output logic [NUM_COLS-1:0] key_col,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic                scan_done,
  output logic                event_8,
  output logic                event_12
);
  localparam int CW = $clog2(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS - 1);
  logic slot_end, scan_end;
  logic [1:0] col;
  logic [NUM_ROWS-1:0] row_s1_q, row_s2_q, rows;
  key_vec_t snap_q, snap_d, prev_q, prev_d, level_q, level_d, level_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q;
  launchpad_key_scanner_scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk_i(CLK),
    .rst_i(RST),
    .slot_end_o(slot_end),
    .col_o(col),
    .key_col_o(key_col)
  );
  // The compare uses the snapshot with column 3 merged in, so level and scan_done land together.
  always_comb begin
    rows = ~row_s2_q;
    snap_d = snap_q;
    if (slot_end) snap_d[{col, 2'b00} +: NUM_ROWS] = rows;
    scan_end = slot_end && col == 2'd3;
    cnt_d = !scan_end ? cnt_q : snap_d != prev_q ? '0 : cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1;
    prev_d = scan_end ? snap_d : prev_q;
    level_d = scan_end && cnt_d == CNT_MAX ? snap_d : level_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
      snap_q <= '0;
      prev_q <= '0;
      cnt_q <= '0;
      level_q <= '0;
      level_dly_q <= '0;
      done_q <= 1'b0;
    end else begin
      row_s1_q <= key_row;
      row_s2_q <= row_s1_q;
      snap_q <= snap_d;
      prev_q <= prev_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      level_dly_q <= level_q;
      done_q <= scan_end;
    end
  end
  assign key_level = level_q;
  assign key_pulse = level_q & ~level_dly_q;
  assign scan_done = done_q;
  assign event_8 = level_q[KEY_EVENT_8];
  assign event_12 = level_q[KEY_EVENT_12];
endmodule
